// File: rtl/sipo_framer.sv
// Serial-in framer: start bit, 4 data bits, optional even-parity bit, stop bit.
// Good words are presented on data_out with a one-cycle load strobe; all outputs registered.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit (sin=0)
// DATA   | shifting in the 4 data bits
// PARITY | checking the even-parity bit
// STOP   | sampling the stop bit, deciding load / error
module sipo_framer #(
  parameter int PARITY_EN = 1,
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  input  logic       bit_en,
  output logic [3:0] data_out,
  output logic       load,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic [7:0] word_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t     state, state_nxt;
  logic [3:0] shreg, shreg_nxt;
  logic [1:0] bit_cnt, bit_cnt_nxt;
  logic       par_bad, par_bad_nxt;
  logic       load_nxt, perr_nxt, ferr_nxt;
  logic [3:0] data_nxt;
  logic [7:0] cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bit_en) begin
      case (state)
        IDLE:    if (!sin) state_nxt = DATA;
        DATA:    if (bit_cnt == 2'd3) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    par_bad_nxt = par_bad;
    load_nxt    = 1'b0;
    perr_nxt    = 1'b0;
    ferr_nxt    = 1'b0;
    data_nxt    = data_out;
    cnt_nxt     = word_cnt;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!sin) begin
            bit_cnt_nxt = 2'd0;
            par_bad_nxt = 1'b0;
          end
        end
        DATA: begin
          shreg_nxt   = (LSB_FIRST != 0) ? {sin, shreg[3:1]} : {shreg[2:0], sin};
          bit_cnt_nxt = bit_cnt + 2'd1;
        end
        PARITY: par_bad_nxt = ^{shreg, sin};
        STOP: begin
          // a bad stop bit masks any parity mismatch
          if (!sin)         ferr_nxt = 1'b1;
          else if (par_bad) perr_nxt = 1'b1;
          else begin
            load_nxt = 1'b1;
            data_nxt = shreg;
            cnt_nxt  = word_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= 4'h0;
      bit_cnt    <= 2'd0;
      par_bad    <= 1'b0;
      data_out   <= 4'h0;
      load       <= 1'b0;
      busy       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      word_cnt   <= 8'h00;
    end else begin
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      par_bad    <= par_bad_nxt;
      data_out   <= data_nxt;
      load       <= load_nxt;
      busy       <= (state_nxt != IDLE);
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
      word_cnt   <= cnt_nxt;
    end
  end

endmodule
